// File: rtl/pci_burst_buffer_if.sv
// Bus bundle between the 68040 local bus / PCI bridge side and the burst buffer.
// slave = buffer side, master = bus/CPU/bridge side.
interface pci_burst_buffer_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned LW = 4
);
  logic          i_nben;
  logic          i_pcidir;
  logic          i_nts;
  logic          i_rnw;
  logic          i_pcicycle;
  logic          i_ntrdy;
  logic          i_nirdy;
  logic [DW-1:0] i_d_in;
  logic [DW-1:0] i_ad_in;
  logic [DW-1:0] o_d_out;
  logic          o_d_oe;
  logic [DW-1:0] o_ad_out;
  logic          o_ad_oe;
  logic          o_nta;
  logic [LW-1:0] o_level;
  logic          o_empty;
  logic          o_full;
  logic          o_overrun;

  modport slave (
    input  i_nben, i_pcidir, i_nts, i_rnw, i_pcicycle, i_ntrdy, i_nirdy, i_d_in, i_ad_in,
    output o_d_out, o_d_oe, o_ad_out, o_ad_oe, o_nta, o_level, o_empty, o_full, o_overrun
  );

  modport master (
    output i_nben, i_pcidir, i_nts, i_rnw, i_pcicycle, i_ntrdy, i_nirdy, i_d_in, i_ad_in,
    input  o_d_out, o_d_oe, o_ad_out, o_ad_oe, o_nta, o_level, o_empty, o_full, o_overrun
  );
endinterface

// File: rtl/pci_burst_buffer.sv
// Single-clock FIFO between the 68040 data bus and the PCI AD bus: buffers CPU write bursts
// for PCI drain and PCI read data for the CPU, generating a registered nTA per beat.
module pci_burst_buffer #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                i_bclk,
  input  logic                i_nreset,
  pci_burst_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(BURST + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCwr  = 2'd1;
  localparam logic [1:0] StCrd  = 2'd2;

  logic [1:0]    r_state, w_state_d;
  logic          r_nta, w_nta_d;
  logic [LW-1:0] r_wrptr, r_rdptr;
  logic [BW-1:0] r_beat, w_beat_d;
  logic          r_pend, w_pend_d;
  logic          r_pend_rnw, w_pend_rnw_d;
  logic          r_ovr;
  logic [DW-1:0] r_mem [DEPTH];

  logic [LW-1:0] w_level, w_level_d;
  logic          w_empty, w_full;
  logic          w_drain, w_fill, w_pop_cpu, w_push_cpu;
  logic          w_pop, w_push_req, w_push;
  logic [DW-1:0] w_push_data, w_head;
  logic          w_req, w_go, w_go_rnw;
  logic          w_beat_fire, w_last;

  assign w_level = r_wrptr - r_rdptr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == LW'(DEPTH));

  assign w_drain    = bus.i_pcidir & bus.i_pcicycle & ~bus.i_ntrdy & ~bus.i_nirdy;
  assign w_fill     = ~bus.i_pcidir & bus.i_pcicycle & ~bus.i_ntrdy & ~bus.i_nirdy;
  assign w_pop_cpu  = (r_state == StCrd) & ~r_nta;
  assign w_push_cpu = (r_state == StCwr) & ~r_nta & bus.i_pcidir;

  assign w_pop       = (w_drain | w_pop_cpu) & ~w_empty;
  assign w_push_req  = w_push_cpu | w_fill;
  // A push into a full FIFO is only legal when the same edge frees an entry.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_push_data = bus.i_pcidir ? bus.i_d_in : bus.i_ad_in;

  assign w_level_d = w_level + {{(LW-1){1'b0}}, w_push} - {{(LW-1){1'b0}}, w_pop};

  assign w_beat_fire = (r_state != StIdle) & ~r_nta;
  assign w_last      = w_beat_fire & (r_beat == BW'(BURST - 1));
  assign w_req       = ~bus.i_nts & ~bus.i_nben;

  always_comb begin
    w_state_d    = r_state;
    w_beat_d     = r_beat;
    w_pend_d     = r_pend;
    w_pend_rnw_d = r_pend_rnw;
    w_go         = 1'b0;
    w_go_rnw     = 1'b0;
    case (r_state)
      StIdle: begin
        // A start held over from a busy period wins; a fresh one then becomes pending.
        if (r_pend) begin
          w_go         = 1'b1;
          w_go_rnw     = r_pend_rnw;
          w_pend_d     = w_req;
          w_pend_rnw_d = w_req ? bus.i_rnw : r_pend_rnw;
        end else begin
          w_go     = w_req;
          w_go_rnw = bus.i_rnw;
        end
        if (w_go) begin
          if (w_go_rnw) begin
            w_state_d = StCrd;
          end else if (bus.i_pcidir) begin
            w_state_d = StCwr;
          end
        end
        w_beat_d = '0;
      end
      StCwr, StCrd: begin
        if (w_req) begin
          w_pend_d     = 1'b1;
          w_pend_rnw_d = bus.i_rnw;
        end
        if (w_last) begin
          w_state_d = StIdle;
          w_beat_d  = '0;
        end else if (w_beat_fire) begin
          w_beat_d = r_beat + 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_nta_d = 1'b1;
    if (w_state_d == StCwr && bus.i_pcidir && w_level_d != LW'(DEPTH)) begin
      w_nta_d = 1'b0;
    end else if (w_state_d == StCrd && !bus.i_pcidir && w_level_d != '0) begin
      w_nta_d = 1'b0;
    end
  end

  always_ff @(posedge i_bclk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state    <= StIdle;
      r_nta      <= 1'b1;
      r_wrptr    <= '0;
      r_rdptr    <= '0;
      r_beat     <= '0;
      r_pend     <= 1'b0;
      r_pend_rnw <= 1'b0;
      r_ovr      <= 1'b0;
    end else if (bus.i_nben) begin
      r_state    <= StIdle;
      r_nta      <= 1'b1;
      r_wrptr    <= '0;
      r_rdptr    <= '0;
      r_beat     <= '0;
      r_pend     <= 1'b0;
      r_pend_rnw <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_nta      <= w_nta_d;
      r_beat     <= w_beat_d;
      r_pend     <= w_pend_d;
      r_pend_rnw <= w_pend_rnw_d;
      if (w_push) r_wrptr <= r_wrptr + 1'b1;
      if (w_pop) r_rdptr <= r_rdptr + 1'b1;
      if (w_push_req && !w_push) r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge i_bclk) begin
    if (w_push && !bus.i_nben) begin
      r_mem[r_wrptr[AW-1:0]] <= w_push_data;
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rdptr[AW-1:0]];

  assign bus.o_d_out   = w_head;
  assign bus.o_ad_out  = w_head;
  assign bus.o_d_oe    = (r_state == StCrd) & ~bus.i_nben;
  assign bus.o_ad_oe   = bus.i_pcidir & bus.i_pcicycle & ~bus.i_nben & ~w_empty;
  assign bus.o_nta     = r_nta;
  assign bus.o_level   = w_level;
  assign bus.o_empty   = w_empty;
  assign bus.o_full    = w_full;
  assign bus.o_overrun = r_ovr;
endmodule

// File: tb/tb_pci_burst_buffer.sv
// Scoreboard bench for pci_burst_buffer: CPU/PCI bus models push expected words,
// a negedge monitor pops and compares them as the buffer hands data out.
module tb_pci_burst_buffer;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BURST = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  pci_burst_buffer_if #(.DW(DW), .LW(LW)) bus ();

  pci_burst_buffer #(.DW(DW), .DEPTH(DEPTH), .BURST(BURST)) u_dut (
    .i_bclk   (clk),
    .i_nreset (nreset),
    .bus      (bus)
  );

  int checks;
  int failures;
  logic [DW-1:0] q_wr [$];
  logic [DW-1:0] q_rd [$];
  logic [DW-1:0] fill_w [8];
  bit saw_full;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data leaving the buffer is compared against the queue filled by the driving models.
  always @(negedge clk) begin
    if (nreset) begin
      if (bus.o_full) saw_full = 1'b1;
      if (bus.o_ad_oe && !bus.i_ntrdy && !bus.i_nirdy) begin
        if (q_wr.size() == 0) check("ad_unexpected_pop", q_wr.size(), 1);
        else check("ad_data", bus.o_ad_out, q_wr.pop_front());
      end
      if (bus.o_d_oe && !bus.o_nta) begin
        if (q_rd.size() == 0) check("d_unexpected_pop", q_rd.size(), 1);
        else check("d_data", bus.o_d_out, q_rd.pop_front());
      end
    end
  end

  // mode 0: plain burst, 1: read start issued mid-burst, 2: reset asserted mid-burst
  task automatic cpu_write(input logic [4*DW-1:0] pk, input int mode);
    logic [DW-1:0] w [4];
    int k;
    bit rd_sent;
    for (int i = 0; i < 4; i++) begin
      w[i] = pk[(3-i)*DW +: DW];
      q_wr.push_back(w[i]);
    end
    rd_sent = 1'b0;
    bus.i_nts  = 1'b0;
    bus.i_rnw  = 1'b0;
    bus.i_d_in = w[0];
    step();
    bus.i_nts = 1'b1;
    k = 0;
    for (int c = 0; c < 200 && k < 4; c++) begin
      @(negedge clk);
      if (!bus.o_nta) k++;
      if (mode == 2 && k == 2) begin
        #1 nreset = 1'b0;
        #1;
        check("rst_nta", bus.o_nta, 1);
        check("rst_level", bus.o_level, 0);
        check("rst_empty", bus.o_empty, 1);
        check("rst_d_out", bus.o_d_out, 0);
        q_wr.delete();
        step();
        nreset = 1'b1;
        return;
      end
      step();
      if (k < 4) bus.i_d_in = w[k];
      if (mode == 1 && k == 2 && !rd_sent) begin
        bus.i_nts = 1'b0;
        bus.i_rnw = 1'b1;
        rd_sent   = 1'b1;
      end else begin
        bus.i_nts = 1'b1;
        bus.i_rnw = 1'b0;
      end
    end
    check("cwr_beats", k, 4);
  endtask

  task automatic cpu_read(input bit issue, input bit chk_gap);
    int k;
    int run;
    int maxrun;
    if (issue) begin
      bus.i_nts = 1'b0;
      bus.i_rnw = 1'b1;
      step();
      bus.i_nts = 1'b1;
      bus.i_rnw = 1'b0;
    end
    k = 0;
    run = 0;
    maxrun = 0;
    for (int c = 0; c < 300 && k < 4; c++) begin
      @(negedge clk);
      if (!bus.o_nta) begin
        k++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("crd_beats", k, 4);
    if (chk_gap) check("crd_nta_run", maxrun, 1);
  endtask

  task automatic pci_drain(input int cycles, input int gap);
    bus.i_pcicycle = 1'b1;
    bus.i_nirdy    = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      bus.i_ntrdy = (gap == 0) ? 1'b0 : ((c % (gap + 1)) != 0);
      step();
    end
    bus.i_pcicycle = 1'b0;
    bus.i_ntrdy    = 1'b1;
    bus.i_nirdy    = 1'b1;
  endtask

  task automatic pci_fill(input int n, input int gap, input bit track);
    for (int i = 0; i < n; i++) begin
      bus.i_pcicycle = 1'b1;
      bus.i_nirdy    = 1'b0;
      bus.i_ntrdy    = 1'b0;
      bus.i_ad_in    = fill_w[i];
      if (track) q_rd.push_back(fill_w[i]);
      step();
      bus.i_ntrdy = 1'b1;
      repeat (gap) step();
    end
    bus.i_pcicycle = 1'b0;
    bus.i_ntrdy    = 1'b1;
    bus.i_nirdy    = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    saw_full = 1'b0;
    nreset = 1'b0;
    bus.i_nben = 1'b0;
    bus.i_pcidir = 1'b1;
    bus.i_nts = 1'b1;
    bus.i_rnw = 1'b0;
    bus.i_pcicycle = 1'b0;
    bus.i_ntrdy = 1'b1;
    bus.i_nirdy = 1'b1;
    bus.i_d_in = '0;
    bus.i_ad_in = '0;
    repeat (2) step();
    check("reset_nta", bus.o_nta, 1);
    check("reset_d_oe", bus.o_d_oe, 0);
    check("reset_ad_oe", bus.o_ad_oe, 0);
    check("reset_d_out", bus.o_d_out, 0);
    check("reset_ad_out", bus.o_ad_out, 0);
    check("reset_level", bus.o_level, 0);
    check("reset_empty", bus.o_empty, 1);
    check("reset_full", bus.o_full, 0);
    check("reset_overrun", bus.o_overrun, 0);
    nreset = 1'b1;
    step();

    // Single write burst, target always ready.
    fork
      cpu_write({32'hFF000000, 32'hEEEE1111, 32'hDDDD2222, 32'hCCCC3333}, 0);
      pci_drain(20, 0);
    join
    check("t1_empty", bus.o_empty, 1);
    check("t1_left", q_wr.size(), 0);
    check("t1_nta_idle", bus.o_nta, 1);

    // Two back-to-back bursts against a slow target: must stall on FULL, never overrun.
    saw_full = 1'b0;
    fork
      begin
        cpu_write({32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004}, 0);
        cpu_write({32'h50000005, 32'h60000006, 32'h70000007, 32'h80000008}, 0);
      end
      pci_drain(120, 2);
    join
    check("t2_saw_full", saw_full, 1);
    check("t2_overrun", bus.o_overrun, 0);
    check("t2_left", q_wr.size(), 0);
    check("t2_empty", bus.o_empty, 1);

    // CPU read with PCI supplying one word every three clocks.
    bus.i_pcidir = 1'b0;
    fill_w[0] = 32'h0000AAAA;
    fill_w[1] = 32'h1111BBBB;
    fill_w[2] = 32'h2222CCCC;
    fill_w[3] = 32'h3333DDDD;
    fork
      cpu_read(1'b1, 1'b1);
      pci_fill(4, 2, 1'b1);
    join
    step();
    check("t3_left", q_rd.size(), 0);
    check("t3_empty", bus.o_empty, 1);
    check("t3_d_oe_idle", bus.o_d_oe, 0);

    // Overfill with nobody reading: last word refused, flush clears everything.
    for (int i = 0; i < 8; i++) fill_w[i] = 32'h40000000 + i;
    pci_fill(DEPTH + 1, 0, 1'b0);
    check("t4_full", bus.o_full, 1);
    check("t4_overrun", bus.o_overrun, 1);
    check("t4_level", bus.o_level, DEPTH);
    check("t4_head", bus.o_ad_out, fill_w[0]);
    bus.i_nben = 1'b1;
    step();
    check("t4_flush_level", bus.o_level, 0);
    check("t4_flush_empty", bus.o_empty, 1);
    check("t4_flush_full", bus.o_full, 0);
    check("t4_flush_overrun", bus.o_overrun, 0);
    bus.i_nben = 1'b0;
    step();

    // Read start arrives during a write burst: held until the burst finishes.
    bus.i_pcidir = 1'b1;
    fork
      cpu_write({32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 32'hA5A50004}, 1);
      pci_drain(60, 2);
    join
    check("t5_wr_left", q_wr.size(), 0);
    check("t5_crd_waiting", bus.o_d_oe, 1);
    check("t5_nta_wait", bus.o_nta, 1);
    bus.i_pcidir = 1'b0;
    fill_w[0] = 32'h5A5A0001;
    fill_w[1] = 32'h5A5A0002;
    fill_w[2] = 32'h5A5A0003;
    fill_w[3] = 32'h5A5A0004;
    fork
      cpu_read(1'b0, 1'b0);
      pci_fill(4, 1, 1'b1);
    join
    step();
    check("t5_rd_left", q_rd.size(), 0);

    // Reset in the middle of a write burst, then a clean burst afterwards.
    bus.i_pcidir = 1'b1;
    cpu_write({32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004}, 2);
    step();
    check("t6_level_after_rst", bus.o_level, 0);
    fork
      cpu_write({32'h600D0001, 32'h600D0002, 32'h600D0003, 32'h600D0004}, 0);
      pci_drain(20, 0);
    join
    check("t6_left", q_wr.size(), 0);
    check("t6_empty", bus.o_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
